// File: rtl/master_mux_mside_reg_if.sv
// Request/beat bus between arbitrated masters, the registered master-side mux and the slave side.
// The master modport is the mux's view; the slave modport is the view of whatever surrounds it.
interface master_mux_mside_reg_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int BURST_W     = 4
);
    logic [NUM_MASTERS-1:0]         bus_grant;
    logic [NUM_MASTERS-1:0]         m_master_valid;
    logic [NUM_MASTERS-1:0]         m_read_en;
    logic [NUM_MASTERS-1:0]         m_write_en;
    logic [NUM_MASTERS*ADDR_W-1:0]  m_tx_address;
    logic [NUM_MASTERS*DATA_W-1:0]  m_tx_data;
    logic [NUM_MASTERS*BURST_W-1:0] m_tx_burst;
    logic [NUM_MASTERS-1:0]         m_master_ready;

    logic                           to_slave_master_valid;
    logic                           to_slave_master_ready;
    logic                           to_slave_read_en;
    logic                           to_slave_write_en;
    logic [ADDR_W-1:0]              to_slave_tx_address;
    logic [DATA_W-1:0]              to_slave_tx_data;
    logic [BURST_W-1:0]             to_slave_tx_burst;

    modport master (
        input  bus_grant, m_master_valid, m_read_en, m_write_en,
        input  m_tx_address, m_tx_data, m_tx_burst, to_slave_master_ready,
        output m_master_ready, to_slave_master_valid, to_slave_read_en, to_slave_write_en,
        output to_slave_tx_address, to_slave_tx_data, to_slave_tx_burst
    );

    modport slave (
        output bus_grant, m_master_valid, m_read_en, m_write_en,
        output m_tx_address, m_tx_data, m_tx_burst, to_slave_master_ready,
        input  m_master_ready, to_slave_master_valid, to_slave_read_en, to_slave_write_en,
        input  to_slave_tx_address, to_slave_tx_data, to_slave_tx_burst
    );
endinterface

// File: rtl/master_mux_mside_reg.sv
// Registered N-master mux: picks the granted master, registers one beat with valid/ready
// backpressure, and locks the selection for the whole burst.
module master_mux_mside_reg #(
    parameter int  NUM_MASTERS = 2,
    parameter int  ADDR_W      = 16,
    parameter int  DATA_W      = 8,
    parameter int  BURST_W     = 4,
    localparam int SEL_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    master_mux_mside_reg_if.master bus,
    output logic [SEL_W-1:0]       sel_idx,
    output logic                   busy,
    output logic                   grant_err
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t               state;
    logic [BURST_W-1:0]   remaining;
    logic                 vld_p1;
    logic                 rd_p1;
    logic                 wr_p1;
    logic [ADDR_W-1:0]    addr_p1;
    logic [DATA_W-1:0]    data_p1;
    logic [BURST_W-1:0]   burst_p1;

    logic                 grant_onehot;
    logic [SEL_W-1:0]     grant_idx;
    logic [SEL_W-1:0]     cur_idx;
    logic                 path_open;
    logic                 can_accept;
    logic                 capture;
    logic [ADDR_W-1:0]    sel_addr_p0;
    logic [DATA_W-1:0]    sel_data_p0;
    logic [BURST_W-1:0]   sel_burst_p0;
    logic [BURST_W-1:0]   first_rem_p0;

    // Stage p0: grant decode and combinational select of the candidate beat.
    always_comb begin
        grant_onehot = $onehot(bus.bus_grant);
        grant_idx    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (bus.bus_grant[i]) grant_idx = SEL_W'(i);
        end
    end

    assign cur_idx    = (state == XFER) ? sel_idx : grant_idx;
    // Ready is gated by rstn so every output reads 0 while reset is held.
    assign path_open  = rstn & ((state == XFER) | grant_onehot);
    assign can_accept = ~vld_p1 | bus.to_slave_master_ready;
    assign capture    = path_open & can_accept & bus.m_master_valid[cur_idx];

    always_comb begin
        bus.m_master_ready = '0;
        if (path_open && can_accept) bus.m_master_ready[cur_idx] = 1'b1;
    end

    assign sel_addr_p0  = bus.m_tx_address[cur_idx*ADDR_W +: ADDR_W];
    assign sel_data_p0  = bus.m_tx_data[cur_idx*DATA_W +: DATA_W];
    assign sel_burst_p0 = bus.m_tx_burst[cur_idx*BURST_W +: BURST_W];
    assign first_rem_p0 = (sel_burst_p0 == '0) ? '0 : sel_burst_p0 - 1'b1;

    // Stage p1: single-entry output register and burst-lock FSM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            remaining <= '0;
            sel_idx   <= '0;
            grant_err <= 1'b0;
            vld_p1    <= 1'b0;
            rd_p1     <= 1'b0;
            wr_p1     <= 1'b0;
            addr_p1   <= '0;
            data_p1   <= '0;
            burst_p1  <= '0;
        end else begin
            grant_err <= (state == IDLE) & ~grant_onehot & (|bus.m_master_valid);
            if (capture) begin
                vld_p1  <= 1'b1;
                rd_p1   <= bus.m_read_en[cur_idx];
                wr_p1   <= bus.m_write_en[cur_idx];
                addr_p1 <= sel_addr_p0;
                data_p1 <= sel_data_p0;
                if (state == IDLE) begin
                    sel_idx   <= grant_idx;
                    burst_p1  <= sel_burst_p0;
                    remaining <= first_rem_p0;
                    state     <= (first_rem_p0 == '0) ? IDLE : XFER;
                end else begin
                    remaining <= remaining - 1'b1;
                    if (remaining == BURST_W'(1)) state <= IDLE;
                end
            end else if (bus.to_slave_master_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign busy                      = (state == XFER);
    assign bus.to_slave_master_valid = vld_p1;
    assign bus.to_slave_read_en      = rd_p1;
    assign bus.to_slave_write_en     = wr_p1;
    assign bus.to_slave_tx_address   = addr_p1;
    assign bus.to_slave_tx_data      = data_p1;
    assign bus.to_slave_tx_burst     = burst_p1;

endmodule

// File: tb/tb_master_mux_mside_reg.sv
// Directed bench for master_mux_mside_reg: a 2-master default instance and a 4-master,
// 32-bit-address instance sharing clock and reset.
module tb_master_mux_mside_reg;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic done = 1'b0;

  logic [0:0] a_sel;
  logic       a_busy, a_err;
  logic [1:0] b_sel;
  logic       b_busy, b_err;

  master_mux_mside_reg_if #(.NUM_MASTERS(2), .ADDR_W(16)) a_if ();
  master_mux_mside_reg_if #(.NUM_MASTERS(4), .ADDR_W(32)) b_if ();

  master_mux_mside_reg #(.NUM_MASTERS(2), .ADDR_W(16), .DATA_W(8), .BURST_W(4)) dut_a (
    .clk(clk), .rstn(rstn), .bus(a_if), .sel_idx(a_sel), .busy(a_busy), .grant_err(a_err)
  );

  master_mux_mside_reg #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(8), .BURST_W(4)) dut_b (
    .clk(clk), .rstn(rstn), .bus(b_if), .sel_idx(b_sel), .busy(b_busy), .grant_err(b_err)
  );

  always #5 clk = ~clk;

  logic [15:0] seen[$];
  always @(posedge clk) begin
    if (a_if.to_slave_master_valid && a_if.to_slave_master_ready)
      seen.push_back(a_if.to_slave_tx_address);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    if (!done) begin
      n_err++;
      $error("FAIL timeout: stimulus did not complete");
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input int i, input logic v, input logic [15:0] addr,
                         input logic [7:0] data, input logic [3:0] burst, input logic rd);
    a_if.m_master_valid[i]        = v;
    a_if.m_read_en[i]             = rd;
    a_if.m_write_en[i]            = ~rd;
    a_if.m_tx_address[i*16 +: 16] = addr;
    a_if.m_tx_data[i*8 +: 8]      = data;
    a_if.m_tx_burst[i*4 +: 4]     = burst;
  endtask

  task automatic drive_b(input int i, input logic v, input logic [31:0] addr,
                         input logic [7:0] data, input logic [3:0] burst);
    b_if.m_master_valid[i]        = v;
    b_if.m_read_en[i]             = 1'b1;
    b_if.m_write_en[i]            = 1'b0;
    b_if.m_tx_address[i*32 +: 32] = addr;
    b_if.m_tx_data[i*8 +: 8]      = data;
    b_if.m_tx_burst[i*4 +: 4]     = burst;
  endtask

  initial begin
    int q0;
    // T1: reset held with all inputs active
    a_if.bus_grant = 2'b01; a_if.m_master_valid = 2'b11;
    a_if.m_read_en = 2'b11; a_if.m_write_en = 2'b11;
    a_if.m_tx_address = '1; a_if.m_tx_data = '1; a_if.m_tx_burst = '1;
    a_if.to_slave_master_ready = 1'b1;
    b_if.bus_grant = 4'b0010; b_if.m_master_valid = 4'hF;
    b_if.m_read_en = '0; b_if.m_write_en = '0;
    b_if.m_tx_address = '1; b_if.m_tx_data = '1; b_if.m_tx_burst = '1;
    b_if.to_slave_master_ready = 1'b1;
    tick(); tick();
    chk("rst_a_valid", a_if.to_slave_master_valid, 1'b0);
    chk("rst_a_ready", a_if.m_master_ready, 2'b00);
    chk("rst_a_addr", a_if.to_slave_tx_address, 16'h0000);
    chk("rst_a_rdwr", {a_if.to_slave_read_en, a_if.to_slave_write_en}, 2'b00);
    chk("rst_a_stat", {a_busy, a_err, a_sel}, 3'b000);
    chk("rst_b_ready", b_if.m_master_ready, 4'b0000);
    chk("rst_b_valid", b_if.to_slave_master_valid, 1'b0);
    a_if.bus_grant = '0; a_if.m_master_valid = '0; a_if.m_read_en = '0; a_if.m_write_en = '0;
    b_if.bus_grant = '0; b_if.m_master_valid = '0;
    rstn = 1'b1;
    tick();
    chk("rel_a_busy", a_busy, 1'b0);
    chk("rel_a_valid", a_if.to_slave_master_valid, 1'b0);
    chk("rel_a_err", a_err, 1'b0);

    // T2: single beat from master 0
    a_if.bus_grant = 2'b01;
    drive_a(0, 1'b1, 16'h1234, 8'hA5, 4'd0, 1'b1);
    #1;
    chk("t2_ready", a_if.m_master_ready, 2'b01);
    tick();
    drive_a(0, 1'b0, 16'h0000, 8'h00, 4'd0, 1'b0);
    chk("t2_valid", a_if.to_slave_master_valid, 1'b1);
    chk("t2_addr", a_if.to_slave_tx_address, 16'h1234);
    chk("t2_data", a_if.to_slave_tx_data, 8'hA5);
    chk("t2_rdwr", {a_if.to_slave_read_en, a_if.to_slave_write_en}, 2'b10);
    chk("t2_sel_busy", {a_sel, a_busy}, 2'b00);
    tick();
    chk("t2_drain", a_if.to_slave_master_valid, 1'b0);

    // T3: 4-beat burst from master 1, grant flips to master 0 after beat 2
    a_if.bus_grant = 2'b10;
    drive_a(1, 1'b1, 16'h2000, 8'h10, 4'd4, 1'b0);
    #1;
    chk("t3_b1_ready", a_if.m_master_ready, 2'b10);
    tick();
    chk("t3_b1_addr", a_if.to_slave_tx_address, 16'h2000);
    chk("t3_b1_busy_sel", {a_busy, a_sel}, 2'b11);
    drive_a(1, 1'b1, 16'h2001, 8'h11, 4'd4, 1'b0);
    tick();
    chk("t3_b2_addr", a_if.to_slave_tx_address, 16'h2001);
    a_if.bus_grant = 2'b01;
    drive_a(0, 1'b1, 16'h0BAD, 8'hEE, 4'd1, 1'b1);
    drive_a(1, 1'b1, 16'h2002, 8'h12, 4'd9, 1'b0);
    #1;
    chk("t3_b3_ready", a_if.m_master_ready, 2'b10);
    tick();
    chk("t3_b3_addr", a_if.to_slave_tx_address, 16'h2002);
    chk("t3_b3_data", a_if.to_slave_tx_data, 8'h12);
    chk("t3_b3_burst", a_if.to_slave_tx_burst, 4'd4);
    chk("t3_b3_busy", a_busy, 1'b1);
    drive_a(1, 1'b1, 16'h2003, 8'h13, 4'd9, 1'b0);
    #1;
    chk("t3_b4_ready", a_if.m_master_ready, 2'b10);
    tick();
    chk("t3_b4_addr", a_if.to_slave_tx_address, 16'h2003);
    chk("t3_b4_busy", a_busy, 1'b0);
    drive_a(1, 1'b0, 16'h0000, 8'h00, 4'd0, 1'b0);
    drive_a(0, 1'b1, 16'h3333, 8'h33, 4'd1, 1'b1);
    #1;
    chk("t3_m0_ready", a_if.m_master_ready, 2'b01);
    tick();
    chk("t3_m0_addr", a_if.to_slave_tx_address, 16'h3333);
    chk("t3_m0_sel", {a_sel, a_busy}, 2'b00);
    drive_a(0, 1'b0, 16'h0000, 8'h00, 4'd0, 1'b0);
    tick();

    // T4: 3-beat burst with slave stalled for 3 cycles after beat 1
    q0 = seen.size();
    a_if.bus_grant = 2'b10;
    drive_a(1, 1'b1, 16'h4000, 8'h40, 4'd3, 1'b1);
    tick();
    a_if.to_slave_master_ready = 1'b0;
    drive_a(1, 1'b1, 16'h4001, 8'h41, 4'd3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stall_ready", a_if.m_master_ready, 2'b00);
      tick();
      chk("t4_stall_addr", a_if.to_slave_tx_address, 16'h4000);
      chk("t4_stall_data", a_if.to_slave_tx_data, 8'h40);
      chk("t4_stall_valid", a_if.to_slave_master_valid, 1'b1);
    end
    a_if.to_slave_master_ready = 1'b1;
    #1;
    chk("t4_resume_ready", a_if.m_master_ready, 2'b10);
    tick();
    chk("t4_b2_addr", a_if.to_slave_tx_address, 16'h4001);
    drive_a(1, 1'b1, 16'h4002, 8'h42, 4'd3, 1'b1);
    tick();
    chk("t4_b3_addr", a_if.to_slave_tx_address, 16'h4002);
    chk("t4_b3_busy", a_busy, 1'b0);
    drive_a(1, 1'b0, 16'h0000, 8'h00, 4'd0, 1'b0);
    tick();
    chk("t4_beats", seen.size() - q0, 3);
    if (seen.size() - q0 == 3) begin
      chk("t4_sb0", seen[q0], 16'h4000);
      chk("t4_sb1", seen[q0+1], 16'h4001);
      chk("t4_sb2", seen[q0+2], 16'h4002);
    end
    chk("t4_empty", a_if.to_slave_master_valid, 1'b0);

    // T5: multi-hot and zero grant with master 0 valid
    a_if.bus_grant = 2'b11;
    drive_a(0, 1'b1, 16'h5A5A, 8'h5A, 4'd0, 1'b1);
    #1;
    chk("t5_11_ready", a_if.m_master_ready, 2'b00);
    tick();
    chk("t5_11_err", a_err, 1'b1);
    chk("t5_11_nocap", a_if.to_slave_master_valid, 1'b0);
    a_if.bus_grant = 2'b00;
    tick();
    chk("t5_00_err", a_err, 1'b1);
    chk("t5_00_nocap", a_if.to_slave_master_valid, 1'b0);
    drive_a(0, 1'b0, 16'h0000, 8'h00, 4'd0, 1'b0);
    tick();
    chk("t5_quiet_err", a_err, 1'b0);

    // T6: reset at beat 2 of an 8-beat burst, both instances
    a_if.bus_grant = 2'b01;
    drive_a(0, 1'b1, 16'h6000, 8'h60, 4'd8, 1'b1);
    b_if.bus_grant = 4'b0100;
    drive_b(2, 1'b1, 32'hDEAD0002, 8'h62, 4'd8);
    #1;
    chk("t6_b_ready", b_if.m_master_ready, 4'b0100);
    tick();
    chk("t6_b_addr", b_if.to_slave_tx_address, 32'hDEAD0002);
    chk("t6_b_sel_busy", {b_sel, b_busy}, 3'b101);
    drive_a(0, 1'b1, 16'h6001, 8'h61, 4'd8, 1'b1);
    tick();
    chk("t6_a_busy", a_busy, 1'b1);
    rstn = 1'b0;
    #1;
    chk("t6_a_valid", a_if.to_slave_master_valid, 1'b0);
    chk("t6_a_addr", a_if.to_slave_tx_address, 16'h0000);
    chk("t6_a_stat", {a_busy, a_sel}, 2'b00);
    chk("t6_a_ready", a_if.m_master_ready, 2'b00);
    chk("t6_b_rvalid", b_if.to_slave_master_valid, 1'b0);
    chk("t6_b_rstat", {b_busy, b_sel}, 3'b000);
    chk("t6_b_raddr", b_if.to_slave_tx_address, 32'h0);
    rstn = 1'b1;
    drive_a(0, 1'b0, 16'h0000, 8'h00, 4'd0, 1'b0);
    a_if.bus_grant = 2'b10;
    drive_a(1, 1'b1, 16'h5555, 8'h55, 4'd1, 1'b1);
    drive_b(2, 1'b0, 32'h0, 8'h00, 4'd0);
    b_if.bus_grant = 4'b1000;
    drive_b(3, 1'b1, 32'hCAFE0003, 8'h63, 4'd0);
    #1;
    chk("t6_a_fresh_ready", a_if.m_master_ready, 2'b10);
    chk("t6_b_fresh_ready", b_if.m_master_ready, 4'b1000);
    tick();
    chk("t6_a_fresh_addr", a_if.to_slave_tx_address, 16'h5555);
    chk("t6_a_fresh_stat", {a_sel, a_busy}, 2'b10);
    chk("t6_b_fresh_addr", b_if.to_slave_tx_address, 32'hCAFE0003);
    chk("t6_b_fresh_stat", {b_sel, b_busy}, 3'b110);
    drive_a(1, 1'b0, 16'h0000, 8'h00, 4'd0, 1'b0);
    drive_b(3, 1'b0, 32'h0, 8'h00, 4'd0);
    tick();

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
